// File: rtl/lenet_pkg.sv
// Shared LeNet5 datapath definitions.
// Class count, index width, score encodings and argmax FSM states.
package lenet_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_WIDTH   = 4;

    localparam int ARITH_FLOAT = 0;
    localparam int ARITH_FIXED = 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_e;

endpackage

// File: rtl/argmax_key_cmp.sv
// Strict greater-than on class scores.
// Both operands are mapped to an unsigned ordering key first.
import lenet_pkg::*;

module argmax_key_cmp #(
    parameter int DATA_WIDTH = 16,
    parameter int ARITH_TYPE = ARITH_FIXED
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    localparam int MSB = DATA_WIDTH - 1;

    function automatic logic [DATA_WIDTH-1:0] key(
        input logic [DATA_WIDTH-1:0] x
    );
        // Float: negatives reverse order, positives sit above them
        if (ARITH_TYPE == ARITH_FIXED)
            key = {~x[MSB], x[MSB-1:0]};
        else if (x[MSB])
            key = ~x;
        else
            key = {1'b1, x[MSB-1:0]};
    endfunction

    assign a_gt_b = key(a) > key(b);

endmodule

// File: rtl/fc_argmax_classifier.sv
// Final LeNet5 stage: captures ten FC class scores and
// serially scans them for the winning digit.
import lenet_pkg::*;

module fc_argmax_classifier #(
    parameter int DATA_WIDTH = 16,
    parameter int ARITH_TYPE = ARITH_FIXED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] score_1,
    input  logic [DATA_WIDTH-1:0] score_2,
    input  logic [DATA_WIDTH-1:0] score_3,
    input  logic [DATA_WIDTH-1:0] score_4,
    input  logic [DATA_WIDTH-1:0] score_5,
    input  logic [DATA_WIDTH-1:0] score_6,
    input  logic [DATA_WIDTH-1:0] score_7,
    input  logic [DATA_WIDTH-1:0] score_8,
    input  logic [DATA_WIDTH-1:0] score_9,
    input  logic [DATA_WIDTH-1:0] score_10,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic [DATA_WIDTH-1:0] max_score
);

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);

    argmax_state_e         state_q, state_d;
    logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
    logic [DATA_WIDTH-1:0] max_score_q, max_score_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  capture;
    logic                  cand_gt;
    logic [DATA_WIDTH-1:0] scores [NUM_CLASSES];
    logic [DATA_WIDTH-1:0] cap_q  [NUM_CLASSES];

    always_comb begin
        scores[0] = score_1;
        scores[1] = score_2;
        scores[2] = score_3;
        scores[3] = score_4;
        scores[4] = score_5;
        scores[5] = score_6;
        scores[6] = score_7;
        scores[7] = score_8;
        scores[8] = score_9;
        scores[9] = score_10;
    end

    argmax_key_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ARITH_TYPE(ARITH_TYPE)
    ) u_cmp (
        .a      (cap_q[cnt_q]),
        .b      (best_val_q),
        .a_gt_b (cand_gt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    best_val_d = score_1;
                    best_idx_d = '0;
                    cnt_d      = IDX_WIDTH'(1);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties
                if (cand_gt) begin
                    best_val_d = cap_q[cnt_q];
                    best_idx_d = cnt_q;
                end
                if (cnt_q == LAST)
                    state_d = DONE;
                else
                    cnt_d = cnt_q + IDX_WIDTH'(1);
            end
            DONE: begin
                class_idx_d = best_idx_q;
                max_score_d = best_val_q;
                done_d      = 1'b1;
                valid_d     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            class_idx_q <= '0;
            max_score_q <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++)
                cap_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            if (capture)
                for (int i = 0; i < NUM_CLASSES; i++)
                    cap_q[i] <= scores[i];
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign result_valid = valid_q;
    assign class_idx    = class_idx_q;
    assign max_score    = max_score_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench for fc_argmax_classifier, fixed and float builds.
module tb_fc_argmax_classifier;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] sc [10];

    logic        busy_fx, done_fx, rv_fx;
    logic [3:0]  idx_fx;
    logic [15:0] max_fx;
    logic        busy_fp, done_fp, rv_fp;
    logic [3:0]  idx_fp;
    logic [15:0] max_fp;

    int checks = 0;
    int errors = 0;
    int lat, nd, bb;

    always #5 clk = ~clk;

    fc_argmax_classifier #(.DATA_WIDTH(16), .ARITH_TYPE(1)) dut_fx (
        .clk(clk), .reset(reset), .start(start),
        .score_1(sc[0]), .score_2(sc[1]), .score_3(sc[2]),
        .score_4(sc[3]), .score_5(sc[4]), .score_6(sc[5]),
        .score_7(sc[6]), .score_8(sc[7]), .score_9(sc[8]),
        .score_10(sc[9]),
        .busy(busy_fx), .done(done_fx), .result_valid(rv_fx),
        .class_idx(idx_fx), .max_score(max_fx)
    );

    fc_argmax_classifier #(.DATA_WIDTH(16), .ARITH_TYPE(0)) dut_fp (
        .clk(clk), .reset(reset), .start(start),
        .score_1(sc[0]), .score_2(sc[1]), .score_3(sc[2]),
        .score_4(sc[3]), .score_5(sc[4]), .score_6(sc[5]),
        .score_7(sc[6]), .score_8(sc[7]), .score_9(sc[8]),
        .score_10(sc[9]),
        .busy(busy_fp), .done(done_fp), .result_valid(rv_fp),
        .class_idx(idx_fp), .max_score(max_fp)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int k = 0; k < 10; k++) sc[k] = v;
    endtask

    // Pulse start, then watch 25 cycles for done/busy behaviour
    task automatic run(input bit fp, input bit disturb,
                       output int l, output int n_done,
                       output int busy_bad);
        logic d, b;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l = -1;
        n_done = 0;
        busy_bad = 0;
        for (int n = 1; n <= 25; n++) begin
            if (n > 1) @(negedge clk);
            d = fp ? done_fp : done_fx;
            b = fp ? busy_fp : busy_fx;
            if (d) begin
                n_done++;
                if (l < 0) l = n - 1;
            end
            if (n <= 10 && !b) busy_bad++;
            if (n == 11 && b) busy_bad++;
            if (disturb && n == 1) fill(16'h7FFF);
            if (disturb && n == 2) start = 1'b1;
            if (disturb && n == 4) start = 1'b0;
        end
    endtask

    initial begin
        fill(16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_fx), 32'd0);
        chk("rst_done", 32'(done_fx), 32'd0);
        chk("rst_rv", 32'(rv_fx), 32'd0);
        chk("rst_idx", 32'(idx_fx), 32'd0);
        chk("rst_max", 32'(max_fx), 32'd0);
        chk("rst_fp_rv", 32'(rv_fp), 32'd0);
        reset = 1'b1;

        // Rising fixed-point scores
        for (int k = 0; k < 10; k++) sc[k] = 16'(16 * (k + 1));
        run(1'b0, 1'b0, lat, nd, bb);
        chk("t1_lat", lat, 32'd10);
        chk("t1_ndone", nd, 32'd1);
        chk("t1_busy", bb, 32'd0);
        chk("t1_idx", 32'(idx_fx), 32'd9);
        chk("t1_max", 32'(max_fx), 32'h00A0);
        chk("t1_rv", 32'(rv_fx), 32'd1);

        // Signed negatives
        fill(16'hFF00);
        sc[3] = 16'hFFF0;
        run(1'b0, 1'b0, lat, nd, bb);
        chk("t2_idx", 32'(idx_fx), 32'd3);
        chk("t2_max", 32'(max_fx), 32'hFFF0);

        // Tie at the maximum
        fill(16'h8000);
        sc[2] = 16'h7FFF;
        sc[6] = 16'h7FFF;
        run(1'b0, 1'b0, lat, nd, bb);
        chk("t3_idx", 32'(idx_fx), 32'd2);
        chk("t3_max", 32'(max_fx), 32'h7FFF);

        // Restart while busy and scores changed after capture
        fill(16'h0100);
        sc[5] = 16'h0200;
        run(1'b0, 1'b1, lat, nd, bb);
        chk("t4_ndone", nd, 32'd1);
        chk("t4_lat", lat, 32'd10);
        chk("t4_idx", 32'(idx_fx), 32'd5);
        chk("t4_max", 32'(max_fx), 32'h0200);

        // Reset in the middle of a scan
        fill(16'h0001);
        sc[8] = 16'h0040;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int n = 0; n < 15; n++) begin
            if (done_fx) nd++;
            @(negedge clk);
        end
        chk("t5_ndone", nd, 32'd0);
        chk("t5_busy", 32'(busy_fx), 32'd0);
        chk("t5_rv", 32'(rv_fx), 32'd0);
        chk("t5_idx", 32'(idx_fx), 32'd0);
        chk("t5_max", 32'(max_fx), 32'd0);
        fill(16'hFF00);
        sc[3] = 16'hFFF0;
        run(1'b0, 1'b0, lat, nd, bb);
        chk("t5b_lat", lat, 32'd10);
        chk("t5b_idx", 32'(idx_fx), 32'd3);
        chk("t5b_max", 32'(max_fx), 32'hFFF0);

        // Half precision: positive beats negatives and -0
        fill(16'h8000);
        sc[0] = 16'hBC00;
        sc[1] = 16'hC000;
        sc[2] = 16'h3800;
        run(1'b1, 1'b0, lat, nd, bb);
        chk("f1_lat", lat, 32'd10);
        chk("f1_idx", 32'(idx_fp), 32'd2);
        chk("f1_max", 32'(max_fp), 32'h3800);

        // All negative, -0.25 is the largest
        fill(16'hBC00);
        sc[1] = 16'hC000;
        sc[4] = 16'hC400;
        sc[6] = 16'hB400;
        run(1'b1, 1'b0, lat, nd, bb);
        chk("f2_idx", 32'(idx_fp), 32'd6);
        chk("f2_max", 32'(max_fp), 32'hB400);

        // +0 orders above -0
        fill(16'h8000);
        sc[8] = 16'h0000;
        run(1'b1, 1'b0, lat, nd, bb);
        chk("f3_idx", 32'(idx_fp), 32'd8);
        chk("f3_max", 32'(max_fp), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
